muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_div_step.sv | 21 ++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// the iteration count and an operand magnitude helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] CNT_LAST   = 5'(ITER_COUNT - 1);

    // Bit 1 of the op selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring divide iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not borrow.
module muldiv_div_step (
    input  logic [31:0] i_rem,
    input  logic        i_bit,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic        o_qbit
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        o_qbit  = ~w_diff[32];
        o_rem   = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO writes accepted here
// CALC    | 32 shift-add / shift-subtract iterations on magnitudes
// FIX     | sign correction, divide-by-zero override, write HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic              hiWe,
    input  logic              loWe,
    output logic              busy,
    output logic              done,
    output logic              divByZero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_e      r_state;
    state_e      w_next;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_b_zero;
    logic [31:0] r_rs;
    logic [31:0] r_opnd;
    logic [63:0] r_prod;

    logic        w_accept;
    logic        w_iter;
    logic        w_fix;
    logic        w_mtx;
    logic        w_in_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [31:0] w_div_rem;
    logic        w_qbit;
    logic [63:0] w_div_next;
    logic [63:0] w_mul_res;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_next = op_is_div(op) ? ST_CALC : ST_FIX;
`else
                    w_next = ST_CALC;
`endif
                end
            end
            ST_CALC: if (r_cnt == CNT_LAST) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != ST_IDLE);
        w_accept = (r_state == ST_IDLE) && start;
        w_mtx    = (r_state == ST_IDLE) && !start;
        w_iter   = (r_state == ST_CALC);
        w_fix    = (r_state == ST_FIX);
    end

    // Multiply holds the multiplicand in r_opnd, the multiplier in r_prod[31:0];
    // divide holds the divisor in r_opnd, the dividend in r_prod[31:0].
    always_comb begin
        w_in_signed = op_is_signed(op);
        w_mag_a     = mag32(rsData, w_in_signed & rsData[31]);
        w_mag_b     = mag32(rtData, w_in_signed & rtData[31]);
        w_mul_sum   = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_opnd : 32'd0)};
        w_mul_next  = {w_mul_sum, r_prod[31:1]};
        w_div_next  = {w_div_rem, r_prod[30:0], w_qbit};
    end

    muldiv_div_step u_div_step (
        .i_rem     (r_prod[63:32]),
        .i_bit     (r_prod[31]),
        .i_divisor (r_opnd),
        .o_rem     (w_div_rem),
        .o_qbit    (w_qbit)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [31:0] r_rt;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;

    always_ff @(posedge clk) begin
        if (rst)           r_rt <= '0;
        else if (w_accept) r_rt <= rtData;
    end

    // Sign/zero extension to 64 bits makes one truncated product serve both.
    always_comb begin
        w_ext_a   = {{32{op_is_signed(r_op) & r_rs[31]}}, r_rs};
        w_ext_b   = {{32{op_is_signed(r_op) & r_rt[31]}}, r_rt};
        w_mul_res = w_ext_a * w_ext_b;
    end
`else
    always_comb begin
        w_mul_res = (r_sign_a ^ r_sign_b) ? (~r_prod + 64'd1) : r_prod;
    end
`endif

    always_comb begin
        w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_prod[31:0] + 32'd1) : r_prod[31:0];
        w_rem_fix = r_sign_a ? (~r_prod[63:32] + 32'd1) : r_prod[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= OP_MULT;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_b_zero  <= 1'b0;
            r_rs      <= '0;
            r_opnd    <= '0;
            r_prod    <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= w_fix;
            if (w_accept) begin
                r_op      <= op;
                r_sign_a  <= w_in_signed & rsData[31];
                r_sign_b  <= w_in_signed & rtData[31];
                r_b_zero  <= (rtData == '0);
                r_rs      <= rsData;
                r_opnd    <= op_is_div(op) ? w_mag_b : w_mag_a;
                r_prod    <= {32'd0, (op_is_div(op) ? w_mag_a : w_mag_b)};
                r_cnt     <= '0;
                divByZero <= 1'b0;
            end else if (w_iter) begin
                r_prod <= op_is_div(r_op) ? w_div_next : w_mul_next;
                r_cnt  <= r_cnt + 5'd1;
            end else if (w_fix) begin
                if (!op_is_div(r_op)) begin
                    hi <= w_mul_res[63:32];
                    lo <= w_mul_res[31:0];
                end else if (r_b_zero) begin
                    hi        <= r_rs;
                    lo        <= '1;
                    divByZero <= 1'b1;
                end else begin
                    hi <= w_rem_fix;
                    lo <= w_quo_fix;
                end
            end else if (w_mtx) begin
                if (hiWe) hi <= rsData;
                if (loWe) lo <= rsData;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level reference model compared every
// cycle, plus literal result and latency expectations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        hiWe;
    logic        loWe;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rsData    (rsData),
        .rtData    (rtData),
        .hiWe      (hiWe),
        .loWe      (loWe),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference result from plain arithmetic on the architectural rules.
    function automatic void compute(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rh, output logic [31:0] rl, output bit z);
        int          ia;
        int          ib;
        longint      ps;
        logic [63:0] pu;
        ia = a;
        ib = b;
        z  = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                ps = longint'(ia) * longint'(ib);
                pu = ps;
                rh = pu[63:32];
                rl = pu[31:0];
            end
            2'b01: begin
                pu = {32'd0, a} * {32'd0, b};
                rh = pu[63:32];
                rl = pu[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    z = 1'b1; rl = 32'hFFFFFFFF; rh = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    rl = 32'h80000000; rh = 32'd0;
                end else begin
                    rl = ia / ib;
                    rh = ia % ib;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    z = 1'b1; rl = 32'hFFFFFFFF; rh = a;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endfunction

    bit          m_valid = 1'b0;
    int          m_left  = 0;
    bit          m_busy, m_done, m_dbz, p_dbz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_dbz   = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_dbz  = p_dbz;
                    m_done = 1'b1;
                end
            end else if (start) begin
                compute(op, rsData, rtData, p_hi, p_lo, p_dbz);
                m_left = op[1] ? DIV_LAT : MUL_LAT;
                m_dbz  = 1'b0;
            end else begin
                if (hiWe) m_hi = rsData;
                if (loWe) m_lo = rsData;
            end
            m_busy = (m_left > 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_divByZero", divByZero, m_dbz);
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic set_idle();
        start = 1'b0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rsData = a;
        rtData = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 60);
        if (!done) $display("FAIL done_timeout: no done within %0d cycles", cyc);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] eh,
                          input logic [31:0] el);
        int cyc;
        issue(o, a, b);
        wait_done(cyc);
        chk({name, "_latency"}, cyc, lat);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int cyc;
        int n_done;
        rst    = 1'b1;
        op     = 2'b00;
        rsData = '0;
        rtData = '0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", divByZero, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        @(posedge clk);
        #1;
        chk("multu_done_pulse_width", done, 0);

        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

        run_op("divu_by_zero", 2'b11, 32'h1234, 32'd0, DIV_LAT, 32'h1234, 32'hFFFFFFFF);
        chk("divu_by_zero_flag", divByZero, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("dbz_held", divByZero, 1);

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        chk("dbz_cleared_on_accept", divByZero, 0);
        wait_done(cyc);
        chk("div_ovf_latency", cyc, DIV_LAT);
        chk("div_ovf_hi", hi, 32'd0);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_flag", divByZero, 0);

        rsData = 32'h5A5A;
        hiWe   = 1'b1;
        loWe   = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
        chk("mthi_both", hi, 32'h5A5A);
        chk("mtlo_both", lo, 32'h5A5A);

        hiWe = 1'b1;
        loWe = 1'b1;
        issue(2'b11, 32'd9, 32'd3);
        chk("start_prio_hi_kept", hi, 32'h5A5A);
        chk("start_prio_lo_kept", lo, 32'h5A5A);
        wait_done(cyc);
        chk("divu_9_3_hi", hi, 32'd0);
        chk("divu_9_3_lo", lo, 32'd3);

        issue(2'b11, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        op     = 2'b01;
        rsData = 32'd2;
        rtData = 32'd3;
        start  = 1'b1;
        hiWe   = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
        wait_done(cyc);
        chk("busy_start_latency", cyc, 23);
        chk("busy_start_hi", hi, 32'd6);
        chk("busy_start_lo", lo, 32'd142);

        issue(2'b01, 32'd6, 32'd7);
        chk("b2b_accepted_busy", busy, 1);
        wait_done(cyc);
        chk("b2b_latency", cyc, MUL_LAT);
        chk("b2b_hi", hi, 32'd0);
        chk("b2b_lo", lo, 32'd42);

        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("rst_mid_no_done", n_done, 0);

        rsData = 32'hABCD;
        loWe   = 1'b1;
        @(posedge clk);
        #1;
        set_idle();
        chk("mtlo_after_rst", lo, 32'hABCD);
        chk("mtlo_after_rst_hi", hi, 0);

        rst    = 1'b1;
        start  = 1'b1;
        op     = 2'b11;
        rsData = 32'd77;
        rtData = 32'd5;
        hiWe   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_hi", hi, 0);
        chk("rst_prio_lo", lo, 0);

        run_op("mult_pos_neg", 2'b00, 32'd100000, 32'hFFFFFFF6, MUL_LAT, 32'hFFFFFFFF, 32'hFFF0BDC0);
        run_op("div_pos_neg", 2'b10, 32'd7, 32'hFFFFFFFE, DIV_LAT, 32'd1, 32'hFFFFFFFD);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
